pwm_deadtime: RTL and testbench



---
 rtl/fcc_pwm_pkg.sv | 18 +
 rtl/dt_leg.sv | 86 ++++++++
 rtl/pwm_deadtime.sv | 65 ++++++
 tb/tb_pwm_deadtime.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fcc_pwm_pkg.sv
// Shared types and constants for the flying-capacitor PWM gate stage.
// Leg FSM state encoding, default dead time and gate index within a pair.
package fcc_pwm_pkg;

  typedef enum logic [2:0] {
    LEG_OFF,
    LEG_DT_HI,
    LEG_HI,
    LEG_DT_LO,
    LEG_LO
  } leg_state_e;

  localparam int DEAD_CYCLES_DEFAULT = 27;

  localparam int HS = 0;
  localparam int LS = 1;

endpackage

// File: rtl/dt_leg.sv
// One complementary switch pair: FSM plus dead-time counter.
// Ports: clk_i, rst_ni, kill_i (force off), cmd_i (1 = high side), hs_o, ls_o, dead_o.
module dt_leg
  import fcc_pwm_pkg::*;
#(
  parameter int DeadCycles = DEAD_CYCLES_DEFAULT,
  parameter int CountWidth = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic kill_i,
  input  logic cmd_i,
  output logic hs_o,
  output logic ls_o,
  output logic dead_o
);

  localparam logic [CountWidth-1:0] LastCnt =
    CountWidth'(DeadCycles - 1);

  leg_state_e            r_state;
  logic [CountWidth-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= LEG_OFF;
      r_cnt   <= '0;
    end else if (kill_i) begin
      r_state <= LEG_OFF;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        LEG_OFF: begin
          // start-up always passes through a full dead interval
          r_state <= cmd_i ? LEG_DT_HI : LEG_DT_LO;
          r_cnt   <= '0;
        end
        LEG_LO: begin
          if (cmd_i) begin
            r_state <= LEG_DT_HI;
            r_cnt   <= '0;
          end
        end
        LEG_HI: begin
          if (!cmd_i) begin
            r_state <= LEG_DT_LO;
            r_cnt   <= '0;
          end
        end
        LEG_DT_HI: begin
          // an abort restarts the interval toward the other side
          if (!cmd_i) begin
            r_state <= LEG_DT_LO;
            r_cnt   <= '0;
          end else if (r_cnt == LastCnt) begin
            r_state <= LEG_HI;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CountWidth'(1);
          end
        end
        LEG_DT_LO: begin
          if (cmd_i) begin
            r_state <= LEG_DT_HI;
            r_cnt   <= '0;
          end else if (r_cnt == LastCnt) begin
            r_state <= LEG_LO;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CountWidth'(1);
          end
        end
        default: begin
          r_state <= LEG_OFF;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign hs_o   = (r_state == LEG_HI);
  assign ls_o   = (r_state == LEG_LO);
  assign dead_o = (r_state == LEG_DT_HI) |
                  (r_state == LEG_DT_LO);

endmodule

// File: rtl/pwm_deadtime.sv
// Dead-time gate stage for the 3-level FCC: two legs, enable, fault latch.
// Ports: clk_i, rst_ni, enable_i, pwm_i[1:0], fault_i, clear_i -> pwm_o[3:0], fault_o, dead_o[1:0].
module pwm_deadtime
  import fcc_pwm_pkg::*;
#(
  parameter int DeadCycles = DEAD_CYCLES_DEFAULT,
  parameter int CountWidth = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       enable_i,
  input  logic [1:0] pwm_i,
  input  logic       fault_i,
  input  logic       clear_i,
  output logic [3:0] pwm_o,
  output logic       fault_o,
  output logic [1:0] dead_o
);

  generate
    if (DeadCycles < 1 || DeadCycles > 255) begin : g_bad_dead
      $error("DeadCycles must be in 1..255");
    end
    if ((64'd1 << CountWidth) <= 64'(DeadCycles)) begin : g_bad_width
      $error("CountWidth too small for DeadCycles");
    end
  endgenerate

  logic [1:0] r_cmd_q;
  logic       r_fault_q;
  logic       w_kill;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_cmd_q   <= 2'b00;
      r_fault_q <= 1'b0;
    end else begin
      r_cmd_q <= pwm_i;
      // a trip present in the same cycle as a clear keeps the latch set
      if (fault_i)
        r_fault_q <= 1'b1;
      else if (clear_i)
        r_fault_q <= 1'b0;
    end
  end

  assign w_kill  = r_fault_q | ~enable_i;
  assign fault_o = r_fault_q;

  for (genvar k = 0; k < 2; k++) begin : g_leg
    dt_leg #(
      .DeadCycles (DeadCycles),
      .CountWidth (CountWidth)
    ) u_leg (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .kill_i (w_kill),
      .cmd_i  (r_cmd_q[k]),
      .hs_o   (pwm_o[2*k+HS]),
      .ls_o   (pwm_o[2*k+LS]),
      .dead_o (dead_o[k])
    );
  end

endmodule

// File: tb/tb_pwm_deadtime.sv
// Self-checking bench for pwm_deadtime at DeadCycles = 27 and 1.
// Run-length reference model plus directed literal checks and random phase.
module tb_pwm_deadtime;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       enable_i;
  logic [1:0] pwm_i;
  logic       fault_i;
  logic       clear_i;

  logic [3:0] p27, p1;
  logic       f27, f1;
  logic [1:0] d27, d1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pwm_deadtime #(.DeadCycles(27), .CountWidth(8)) u_d27 (
    .clk_i(clk), .rst_ni(rst_ni), .enable_i(enable_i),
    .pwm_i(pwm_i), .fault_i(fault_i), .clear_i(clear_i),
    .pwm_o(p27), .fault_o(f27), .dead_o(d27)
  );

  pwm_deadtime #(.DeadCycles(1), .CountWidth(8)) u_d1 (
    .clk_i(clk), .rst_ni(rst_ni), .enable_i(enable_i),
    .pwm_i(pwm_i), .fault_i(fault_i), .clear_i(clear_i),
    .pwm_o(p1), .fault_o(f1), .dead_o(d1)
  );

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h",
               nm, $time, got, exp);
    end
  endtask

  // Reference model: a gate is on once its side has been commanded,
  // without kill, for at least DeadCycles+1 consecutive evaluation edges.
  int         dcy [2] = '{27, 1};
  int         run_hi [2][2];
  int         run_lo [2][2];
  logic [1:0] m_cq;
  logic       m_fq;

  always begin
    logic       s_rst, s_en, s_f, s_c, kill;
    logic [1:0] s_pwm;
    logic [3:0] ep, gp;
    logic [1:0] ed, gd;
    logic       gf;
    @(posedge clk);
    s_rst = rst_ni; s_en = enable_i; s_pwm = pwm_i;
    s_f = fault_i;  s_c = clear_i;
    if (!s_rst) begin
      m_cq = 2'b00;
      m_fq = 1'b0;
      for (int d = 0; d < 2; d++)
        for (int k = 0; k < 2; k++) begin
          run_hi[d][k] = 0;
          run_lo[d][k] = 0;
        end
    end else begin
      kill = m_fq | ~s_en;
      for (int d = 0; d < 2; d++)
        for (int k = 0; k < 2; k++) begin
          if (kill) begin
            run_hi[d][k] = 0;
            run_lo[d][k] = 0;
          end else if (m_cq[k]) begin
            if (run_hi[d][k] < 100000) run_hi[d][k]++;
            run_lo[d][k] = 0;
          end else begin
            if (run_lo[d][k] < 100000) run_lo[d][k]++;
            run_hi[d][k] = 0;
          end
        end
      m_fq = s_f | (m_fq & ~s_c);
      m_cq = s_pwm;
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 2; k++) begin
        ep[2*k]   = run_hi[d][k] >= dcy[d] + 1;
        ep[2*k+1] = run_lo[d][k] >= dcy[d] + 1;
        ed[k]     = (run_hi[d][k] > 0 || run_lo[d][k] > 0) &&
                    !ep[2*k] && !ep[2*k+1];
      end
      gp = (d == 0) ? p27 : p1;
      gd = (d == 0) ? d27 : d1;
      gf = (d == 0) ? f27 : f1;
      chk($sformatf("pwm_o D=%0d", dcy[d]), 32'(gp), 32'(ep));
      chk($sformatf("dead_o D=%0d", dcy[d]), 32'(gd), 32'(ed));
      chk($sformatf("fault_o D=%0d", dcy[d]), 32'(gf), 32'(m_fq));
      chk($sformatf("overlap D=%0d", dcy[d]),
          32'((gp[0] & gp[1]) | (gp[2] & gp[3])), 32'd0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic rose;
    int   hold;
    rst_ni = 1'b0; enable_i = 1'b1; pwm_i = 2'b11;
    fault_i = 1'b0; clear_i = 1'b0;
    step(5);
    chk("reset pwm_o", 32'(p27), 32'd0);
    chk("reset dead_o", 32'(d27), 32'd0);
    chk("reset fault_o", 32'(f27), 32'd0);
    rst_ni = 1'b1;

    // start-up: 28 off edges, then both high sides
    step(28);
    chk("startup off", 32'(p27), 32'd0);
    chk("startup dead", 32'(d27), 32'b11);
    step(1);
    chk("startup on", 32'(p27), 32'b0101);
    chk("startup on D=1", 32'(p1), 32'b0101);

    // enable drop mid-HI
    enable_i = 1'b0;
    step(1);
    chk("enable off", 32'(p27), 32'd0);
    chk("enable no fault", 32'(f27), 32'd0);
    step(2);
    enable_i = 1'b1;
    step(40);

    // one-cycle trip while running
    fault_i = 1'b1;
    step(1);
    fault_i = 1'b0;
    step(1);
    chk("fault gates off", 32'(p27), 32'd0);
    chk("fault latched", 32'(f27), 32'd1);
    fault_i = 1'b1; clear_i = 1'b1;
    step(1);
    fault_i = 1'b0; clear_i = 1'b0;
    chk("fault wins clear", 32'(f27), 32'd1);
    step(3);
    clear_i = 1'b1;
    step(1);
    clear_i = 1'b0;
    chk("fault cleared", 32'(f27), 32'd0);
    step(27);
    chk("resume dead", 32'(p27), 32'd0);
    step(1);
    chk("resume on", 32'(p27), 32'b0101);

    // single commutation on leg 0 from LO, then back
    pwm_i = 2'b00;
    step(40);
    chk("both LO", 32'(p27), 32'b1010);
    pwm_i = 2'b01;
    step(2);
    chk("comm lo off", 32'(p27), 32'b1000);
    step(26);
    chk("comm still dead", 32'(p27), 32'b1000);
    step(1);
    chk("comm hi on", 32'(p27), 32'b1001);
    pwm_i = 2'b00;
    step(2);
    chk("rev hi off", 32'(p27), 32'b1000);
    step(26);
    chk("rev still dead", 32'(p27), 32'b1000);
    step(1);
    chk("rev lo on", 32'(p27), 32'b1010);

    // short pulse: 10 cycles never reaches HI
    step(10);
    rose = 1'b0;
    pwm_i = 2'b01;
    for (int i = 0; i < 10; i++) begin
      step(1);
      rose |= p27[0];
    end
    pwm_i = 2'b00;
    for (int i = 0; i < 28; i++) begin
      step(1);
      rose |= p27[0];
    end
    chk("short pulse no hi", 32'(rose), 32'd0);
    chk("short pulse dead", 32'(p27), 32'b1000);
    step(1);
    chk("short pulse lo back", 32'(p27), 32'b1010);

    // randomized phase
    for (int s = 0; s < 700; s++) begin
      pwm_i    = 2'($urandom);
      enable_i = ($urandom_range(0, 14) != 0);
      fault_i  = ($urandom_range(0, 30) == 0);
      clear_i  = ($urandom_range(0, 5) == 0);
      step(1);
      enable_i = 1'b1; fault_i = 1'b0; clear_i = 1'b0;
      hold = $urandom_range(0, 60);
      if (hold > 0) step(hold);
    end
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
